// File: rtl/dir_lut_pipe.sv
// Orientation-bin lookup: writable 2^AW x DW table feeding a 2-stage valid/ready pipeline.
// Define DIR_LUT_ROT_EN to subtract the per-request rotation from the looked-up bin.
module dir_lut_pipe #(
  parameter int AW = 8,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_rot,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_bin
);

  localparam int STAGES = 2;

  logic [DW-1:0]     lut [2**AW];
  logic [STAGES:1]   vld_pipe;
  logic [DW-1:0]     s1_bin;
  logic [DW-1:0]     s2_bin;
  logic [DW-1:0]     s1_res;
  logic              advance;

  assign advance   = !vld_pipe[1+1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];
  assign out_bin   = s2_bin;

  // No reset on the table so it maps onto RAM; the S1 read sees the pre-write entry.
  always_ff @(posedge clk) begin
    if (cfg_we && !rst) lut[cfg_addr] <= cfg_data;
  end

`ifdef DIR_LUT_ROT_EN
  logic [DW-1:0] s1_rot;

  always_ff @(posedge clk) begin
    if (advance) s1_rot <= in_rot;
  end

  assign s1_res = s1_bin - s1_rot;
`else
  logic unused_rot;

  assign unused_rot = ^in_rot;
  assign s1_res     = s1_bin;
`endif

  always_ff @(posedge clk) begin
    if (advance) s1_bin <= lut[in_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s2_bin   <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[1], in_valid};
      if (vld_pipe[1]) s2_bin <= s1_res;
    end
  end

endmodule
